// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared constants for the decode-stage hazard scoreboard.
//   FWD_SEL_RF  : forward-select value meaning "take the register file".
//   RDY_ALU     : ready-stage index for single-cycle ALU results (EX output).
//   RDY_LOAD    : ready-stage index for load results (MEM output).
//   rdy_mul()   : ready-stage index for the multiplier, which delivers at the
//                 last forwardable stage of whatever pipe depth is configured.
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  localparam int FWD_SEL_RF = 0;
  localparam int RDY_ALU    = 0;
  localparam int RDY_LOAD   = 1;

  function automatic int rdy_mul(input int fwd_stages);
    return fwd_stages - 1;
  endfunction

endpackage

// File: rtl/hs_entry.sv
// -----------------------------------------------------------------------------
// hs_entry
//   Scoreboard entry for one architectural register (index IDX, never 0).
//   Tracks whether a write is in flight, how many stages past decode it has
//   travelled (age) and the first stage whose output carries the value (rdy).
//   Also compares itself against both decode source operands.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : pipeline advance; 0 freezes the entry
//   flush               : discard the in-flight write
//   alloc               : decode accepted an instruction that writes a register
//   dst_addr, dst_rdy   : destination of that instruction, clamped ready stage
//   rs_addr, rs_used    : decode source 1
//   rt_addr, rt_used    : decode source 2
//   pending             : a write to this register is in flight
//   rs_sel, rt_sel      : forward select this entry asks for (0 when no hit)
//   rs_block, rt_block  : source hits but the value is not yet forwardable
// -----------------------------------------------------------------------------
module hs_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int              ADDR_W     = 5,
  parameter int              FWD_STAGES = 2,
  parameter int              SEL_W      = 3,
  parameter logic [ADDR_W-1:0] IDX      = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [SEL_W-1:0]  dst_rdy,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic              rs_used,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rt_used,
  output logic              pending,
  output logic [SEL_W-1:0]  rs_sel,
  output logic              rs_block,
  output logic [SEL_W-1:0]  rt_sel,
  output logic              rt_block
);

  localparam logic [SEL_W-1:0] LAST_AGE = SEL_W'(FWD_STAGES - 1);

  logic             valid;
  logic [SEL_W-1:0] age;
  logic [SEL_W-1:0] rdy;

  logic rs_hit;
  logic rt_hit;
  logic fwd_ok;

  // The register file is write-before-read, so once the write leaves the last
  // forwardable stage the entry can be dropped and the regfile read is correct.
  // NOTE: state uses non-blocking assignments so every entry samples the
  // pre-edge values of en/flush/alloc, regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      age   <= '0;
      rdy   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      if (alloc && dst_addr == IDX) begin
        // Youngest writer replaces any older in-flight write to this register.
        valid <= 1'b1;
        age   <= '0;
        rdy   <= dst_rdy;
      end else if (valid) begin
        if (age == LAST_AGE) valid <= 1'b0;
        else                 age   <= age + 1'b1;
      end
    end
  end

  assign pending = valid;
  assign rs_hit  = valid && rs_used && rs_addr == IDX;
  assign rt_hit  = valid && rt_used && rt_addr == IDX;
  assign fwd_ok  = age >= rdy;

  assign rs_sel   = (rs_hit && fwd_ok) ? age + 1'b1 : SEL_W'(FWD_SEL_RF);
  assign rt_sel   = (rt_hit && fwd_ok) ? age + 1'b1 : SEL_W'(FWD_SEL_RF);
  assign rs_block = rs_hit && !fwd_ok;
  assign rt_block = rt_hit && !fwd_ok;

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Decode-stage hazard unit: one scoreboard entry per register (r != 0)
//   drives operand forward selects, the decode stall and a stall counter.
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   en                     : pipeline advance (0 = memory wait, freeze)
//   flush                  : discard all in-flight writes
//   issue_valid            : a valid instruction is in decode
//   rs_addr/rs_used        : source 1 address / is read
//   rt_addr/rt_used        : source 2 address / is read
//   dst_addr/dst_we        : destination address / is written
//   dst_rdy                : first stage whose output carries the result
//   stall                  : hold fetch/decode, bubble into EX
//   rs_fwd_sel/rt_fwd_sel  : 0 = regfile, k+1 = forward from stage k
//   pending_mask           : bit r set while register r has a write in flight
//   stall_cnt              : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = 3,
  parameter int CNT_W      = 32,
  localparam int NUM_REGS  = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   rs_addr,
  input  logic                rs_used,
  input  logic [ADDR_W-1:0]   rt_addr,
  input  logic                rt_used,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic                dst_we,
  input  logic [SEL_W-1:0]    dst_rdy,
  output logic                stall,
  output logic [SEL_W-1:0]    rs_fwd_sel,
  output logic [SEL_W-1:0]    rt_fwd_sel,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [SEL_W-1:0] MAX_RDY = SEL_W'(FWD_STAGES - 1);

  logic [NUM_REGS-1:0][SEL_W-1:0] rs_sel_e;
  logic [NUM_REGS-1:0][SEL_W-1:0] rt_sel_e;
  logic [NUM_REGS-1:0]            rs_block_e;
  logic [NUM_REGS-1:0]            rt_block_e;

  logic             accept;
  logic             alloc;
  logic [SEL_W-1:0] rdy_clamped;

  // A producer that claims a later stage than exists is treated as ready at
  // the last forwardable stage.
  assign rdy_clamped = (dst_rdy > MAX_RDY) ? MAX_RDY : dst_rdy;
  assign accept      = issue_valid && !stall && en && !flush;
  assign alloc       = accept && dst_we;

  // Register 0 is hard-wired zero and never tracked.
  assign pending_mask[0] = 1'b0;
  assign rs_sel_e[0]     = '0;
  assign rt_sel_e[0]     = '0;
  assign rs_block_e[0]   = 1'b0;
  assign rt_block_e[0]   = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hs_entry #(
      .ADDR_W     (ADDR_W),
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W),
      .IDX        (ADDR_W'(r))
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .flush    (flush),
      .alloc    (alloc),
      .dst_addr (dst_addr),
      .dst_rdy  (rdy_clamped),
      .rs_addr  (rs_addr),
      .rs_used  (rs_used),
      .rt_addr  (rt_addr),
      .rt_used  (rt_used),
      .pending  (pending_mask[r]),
      .rs_sel   (rs_sel_e[r]),
      .rs_block (rs_block_e[r]),
      .rt_sel   (rt_sel_e[r]),
      .rt_block (rt_block_e[r])
    );
  end

  // At most one entry can hit per source, so the selects OR together.
  // NOTE: every output of this block gets a default first so no latch forms.
  always_comb begin
    rs_fwd_sel = SEL_W'(FWD_SEL_RF);
    rt_fwd_sel = SEL_W'(FWD_SEL_RF);
    for (int r = 0; r < NUM_REGS; r++) begin
      rs_fwd_sel = rs_fwd_sel | rs_sel_e[r];
      rt_fwd_sel = rt_fwd_sel | rt_sel_e[r];
    end
  end

  assign stall = issue_valid && (|rs_block_e || |rt_block_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     stall_cnt <= '0;
    else if (en && stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed bench. dut uses FWD_STAGES=2 with a 32-bit stall counter; dut4
//   uses FWD_STAGES=4 with a 2-bit counter so saturation is reachable. Both
//   see the same stimulus; each step checks only the instance it targets.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic       issue_valid;
  logic [4:0] rs_addr;
  logic       rs_used;
  logic [4:0] rt_addr;
  logic       rt_used;
  logic [4:0] dst_addr;
  logic       dst_we;
  logic [2:0] dst_rdy;

  logic        stall,  stall4;
  logic [2:0]  rs_sel, rs_sel4;
  logic [2:0]  rt_sel, rt_sel4;
  logic [31:0] mask,   mask4;
  logic [31:0] cnt;
  logic [1:0]  cnt4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.ADDR_W(5), .FWD_STAGES(2), .SEL_W(3), .CNT_W(32)) dut (
    .clk (clk), .rst_n (rst_n), .en (en), .flush (flush),
    .issue_valid (issue_valid),
    .rs_addr (rs_addr), .rs_used (rs_used),
    .rt_addr (rt_addr), .rt_used (rt_used),
    .dst_addr (dst_addr), .dst_we (dst_we), .dst_rdy (dst_rdy),
    .stall (stall), .rs_fwd_sel (rs_sel), .rt_fwd_sel (rt_sel),
    .pending_mask (mask), .stall_cnt (cnt)
  );

  hazard_scoreboard #(.ADDR_W(5), .FWD_STAGES(4), .SEL_W(3), .CNT_W(2)) dut4 (
    .clk (clk), .rst_n (rst_n), .en (en), .flush (flush),
    .issue_valid (issue_valid),
    .rs_addr (rs_addr), .rs_used (rs_used),
    .rt_addr (rt_addr), .rt_used (rt_used),
    .dst_addr (dst_addr), .dst_we (dst_we), .dst_rdy (dst_rdy),
    .stall (stall4), .rs_fwd_sel (rs_sel4), .rt_fwd_sel (rt_sel4),
    .pending_mask (mask4), .stall_cnt (cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked one
  // unit later, well clear of either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; rs_used = 1'b0; rt_used = 1'b0; dst_we = 1'b0;
    rs_addr = '0; rt_addr = '0; dst_addr = '0; dst_rdy = '0;
  endtask

  task automatic produce(input logic [4:0] dst, input logic [2:0] rdy);
    idle();
    issue_valid = 1'b1; dst_addr = dst; dst_we = 1'b1; dst_rdy = rdy;
    #1;
  endtask

  task automatic consume_rs(input logic [4:0] src);
    idle();
    issue_valid = 1'b1; rs_addr = src; rs_used = 1'b1;
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; flush = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // ---- 1: async reset in the middle of a stall ----
    tick(); produce(5'd7, 3'd3);
    check("t1_no_stall_on_produce", {31'd0, stall4}, 32'd0);
    tick(); consume_rs(5'd7);
    check("t1_dut4_stall_first", {31'd0, stall4}, 32'd1);
    tick(); #1;
    check("t1_dut4_stall_held", {31'd0, stall4}, 32'd1);
    check("t1_dut4_cnt_before_rst", {30'd0, cnt4}, 32'd1);
    check("t1_dut_fwd_after_load", {29'd0, rs_sel}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("t1_rst_stall", {31'd0, stall4}, 32'd0);
    check("t1_rst_mask", mask4, 32'd0);
    check("t1_rst_cnt", {30'd0, cnt4}, 32'd0);
    check("t1_rst_dut_cnt", cnt, 32'd0);
    idle();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check("t1_idle_outputs", {stall, rs_sel, rt_sel}, 32'd0);
      check("t1_idle_mask", mask, 32'd0);
      check("t1_idle_cnt", cnt, 32'd0);
    end

    // ---- 2: ALU producer forwarded from EX, then MEM, then regfile ----
    tick(); produce(5'd5, 3'd0);
    tick(); consume_rs(5'd5);
    check("t2_stall", {31'd0, stall}, 32'd0);
    check("t2_sel_ex", {29'd0, rs_sel}, 32'd1);
    tick(); #1;
    check("t2_sel_mem", {29'd0, rs_sel}, 32'd2);
    tick(); #1;
    check("t2_sel_rf", {29'd0, rs_sel}, 32'd0);
    check("t2_mask5", {31'd0, mask[5]}, 32'd0);

    // ---- 3: load-use ----
    tick(); produce(5'd8, 3'd1);
    tick(); idle(); issue_valid = 1'b1; rt_addr = 5'd8; rt_used = 1'b1; #1;
    check("t3_stall", {31'd0, stall}, 32'd1);
    check("t3_sel_during_stall", {29'd0, rt_sel}, 32'd0);
    tick(); #1;
    check("t3_stall_released", {31'd0, stall}, 32'd0);
    check("t3_rt_sel", {29'd0, rt_sel}, 32'd2);
    check("t3_cnt", cnt, 32'd1);

    // ---- 4: MUL on the 4-stage instance ----
    tick(); idle(); pulse_reset();
    tick(); produce(5'd9, 3'd3);
    tick(); consume_rs(5'd9);
    check("t4_stall_age0", {31'd0, stall4}, 32'd1);
    check("t4_sel_age0", {29'd0, rs_sel4}, 32'd0);
    tick(); #1;
    check("t4_stall_age1", {31'd0, stall4}, 32'd1);
    tick(); #1;
    check("t4_stall_age2", {31'd0, stall4}, 32'd1);
    tick(); #1;
    check("t4_stall_done", {31'd0, stall4}, 32'd0);
    check("t4_rs_sel", {29'd0, rs_sel4}, 32'd4);
    check("t4_cnt", {30'd0, cnt4}, 32'd3);
    check("t4_dut_rdy_clamped_cnt", cnt, 32'd1);

    // ---- 5: WAW, youngest writer wins ----
    tick(); idle(); flush = 1'b1;
    tick(); flush = 1'b0; produce(5'd3, 3'd1);
    tick(); produce(5'd3, 3'd0);
    tick(); consume_rs(5'd3);
    check("t5_stall", {31'd0, stall}, 32'd0);
    check("t5_rs_sel", {29'd0, rs_sel}, 32'd1);

    // ---- 6: corner cases ----
    tick(); idle(); flush = 1'b1;
    tick(); flush = 1'b0; #1;
    check("t6_flush_clean", mask, 32'd0);
    produce(5'd0, 3'd0);
    tick(); idle(); #1;
    check("t6_dst0_mask", mask, 32'd0);

    produce(5'd10, 3'd1);
    tick(); idle(); issue_valid = 1'b1;
    rt_addr = 5'd10; rt_used = 1'b0; rs_addr = 5'd0; rs_used = 1'b1; #1;
    check("t6_rt_unused_stall", {31'd0, stall}, 32'd0);
    check("t6_rt_unused_sel", {26'd0, rs_sel, rt_sel}, 32'd0);
    check("t6_rt_unused_mask", mask, 32'h0000_0400);

    tick(); produce(5'd12, 3'd1);
    tick(); consume_rs(5'd12);
    check("t6_en_stall", {31'd0, stall}, 32'd1);
    check("t6_en_mask", mask, 32'h0000_1000);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check("t6_frozen_stall", {31'd0, stall}, 32'd1);
      check("t6_frozen_cnt", cnt, 32'd1);
    end
    en = 1'b1;
    tick(); #1;
    check("t6_resume_stall", {31'd0, stall}, 32'd0);
    check("t6_resume_sel", {29'd0, rs_sel}, 32'd2);
    check("t6_resume_cnt", cnt, 32'd2);

    tick(); produce(5'd14, 3'd1);
    tick(); consume_rs(5'd14); flush = 1'b1; #1;
    check("t6_pre_flush_stall", {31'd0, stall}, 32'd1);
    tick(); flush = 1'b0; #1;
    check("t6_flush_stall", {31'd0, stall}, 32'd0);
    check("t6_flush_mask", mask, 32'd0);
    check("t6_flush_sel", {29'd0, rs_sel}, 32'd0);
    check("t6_flush_cnt", cnt, 32'd3);
    check("t6_dut4_cnt_saturated", {30'd0, cnt4}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised decode-stage hazard unit for the pipelined MIPS core. It replaces fixed EX/MEM compare-based forwarding and single-cycle load-use stall logic with a per-register scoreboard. Each tracked write records its pipeline age and the stage at which its result becomes forwardable. This supports any number of forwarding stages and multi-cycle producers (loads, MUL, future long-latency units), and drives the operand forward muxes and the decode stall.

Parameters:
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
FWD_STAGES, 2, forwardable stages after decode (stage 0 = EX, 1 = MEM, ...), range 1..7
SEL_W, 3, forward-select width; must hold FWD_STAGES
CNT_W, 32, stall-cycle counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
en  in  1  pipeline advance; 0 freezes the whole pipe (memory wait)
flush  in  1  discard all in-flight writes (exception/redirect)
issue_valid  in  1  a valid instruction is in decode
rs_addr  in  ADDR_W  source 1 address
rs_used  in  1  instruction reads rs
rt_addr  in  ADDR_W  source 2 address
rt_used  in  1  instruction reads rt
dst_addr  in  ADDR_W  destination register
dst_we  in  1  instruction writes dst_addr
dst_rdy  in  SEL_W  first stage index whose output carries the result (ALU 0, load 1, MUL FWD_STAGES-1)
stall  out  1  hold decode/fetch, inject bubble into EX
rs_fwd_sel  out  SEL_W  0 = regfile, k+1 = forward from stage k
rt_fwd_sel  out  SEL_W  same encoding, for rt
pending_mask  out  NUM_REGS  bit r set while register r has a tracked in-flight write
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- State: one entry per register r≠0: valid, age (0..FWD_STAGES-1), rdy.
- Reset (rst_n low, async): all entries invalid, stall_cnt=0. Outputs: stall=0, both fwd_sel=0, pending_mask=0.
- Outputs are combinational from state and decode inputs; zero input-to-state latency.
- Source match: used & addr≠0 & entry[addr].valid.
- For a source match: fwd_sel = age+1 if age ≥ rdy, else 0.
- No match: fwd_sel = 0.
- stall = issue_valid & (rs match with age < rdy | rt match with age < rdy).
- Accept = issue_valid & ~stall & en & ~flush.
- Clock edge, en=1, flush=0:
  - Every valid entry age+1.
  - An entry reaching age==FWD_STAGES is cleared; the value is now in the regfile, which is write-before-read.
  - On accept with dst_we & dst_addr≠0: entry[dst_addr] ← {1, age 0, min(dst_rdy, FWD_STAGES-1)}.
  - The new entry overwrites any aging entry for that register in the same edge, so the youngest writer wins (in-order WB makes WAW safe).
- Stall cycles still age entries, because the bubble advances the later stages.
- en=0: all state held; stall and fwd_sel still reflect current state; stall_cnt does not count.
- flush=1 at an edge: all entries cleared regardless of en or issue; takes priority over accept.
- stall_cnt: +1 on each edge with en=1 & stall=1; holds at all-ones.
- Mid-operation async reset: state cleared immediately; stall drops in the same cycle.
- FWD_STAGES=1: only EX forwarding; sel is 0 or 1.

Decomposition:
- Shared header hazard_defines.v, alongside mips_defines.v, holds:
  - FWD_SEL_RF = 0
  - Ready-stage constants RDY_ALU=0, RDY_LOAD=1, RDY_MUL.
- Sub-module hs_entry holds one register's valid/age/rdy state, its aging and overwrite logic, and its own compare. It is instantiated NUM_REGS-1 times by generate.
- Top level holds the select muxes, the stall OR-reduction and stall_cnt.

Test Plan:
1. Assert rst_n=0 mid-stall → same cycle stall=0, pending_mask=0, stall_cnt=0; release, then idle 5 cycles → outputs remain 0.
2. Issue dst=5 rdy=0 (FWD_STAGES=2); next cycle rs=5 used → stall=0, rs_fwd_sel=1; following cycle rs_fwd_sel=2; third cycle rs_fwd_sel=0, pending_mask[5]=0.
3. Load-use: issue dst=8 rdy=1, then consumer with rt=8 → stall=1 for exactly 1 cycle, then rt_fwd_sel=2; stall_cnt=1.
4. FWD_STAGES=4: MUL dst=9 rdy=3, consumer rs=9 next → stall 3 cycles, then rs_fwd_sel=4; stall_cnt=3.
5. WAW: issue dst=3 rdy=1, then dst=3 rdy=0, then consumer rs=3 → stall=0, rs_fwd_sel=1.
6. Corner cases:
   - dst=0 → no pending bit set.
   - rt_used=0 against a pending rt → no stall.
   - en=0 for 4 cycles during a load-use stall → stall stays 1, stall_cnt unchanged.
   - flush → stall=0 on the next cycle, pending_mask=0.
